// File: rtl/regfile_writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_arbiter_pkg
// Purpose  : Shared widths, constants and the writeback entry type.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_writeback_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_arbiter_if
// Purpose  : Source, scoreboard and register-file write signals of the
//            writeback arbiter. Bypass ports exist only with WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_writeback_arbiter_if
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int XLEN_P       = XLEN,
    parameter int REG_ADDR_W_P = REG_ADDR_W
);
    logic                       alu_valid;
    logic [REG_ADDR_W_P-1:0]    alu_rd;
    logic [XLEN_P-1:0]          alu_data;
    logic                       lsu_valid;
    logic                       lsu_ready;
    logic [REG_ADDR_W_P-1:0]    lsu_rd;
    logic [XLEN_P-1:0]          lsu_data;
    logic                       issue_valid;
    logic [REG_ADDR_W_P-1:0]    issue_rd;
    logic [2**REG_ADDR_W_P-1:0] pending;
    logic                       we;
    logic [REG_ADDR_W_P-1:0]    rd;
    logic [XLEN_P-1:0]          wd;
`ifdef WB_BYPASS_EN
    logic [REG_ADDR_W_P-1:0]    byp_rs1;
    logic [REG_ADDR_W_P-1:0]    byp_rs2;
    logic                       byp_hit1;
    logic                       byp_hit2;
    logic [XLEN_P-1:0]          byp_data1;
    logic [XLEN_P-1:0]          byp_data2;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd,
        input  lsu_ready, pending, we, rd, wd
`ifdef WB_BYPASS_EN
        ,
        output byp_rs1, byp_rs2,
        input  byp_hit1, byp_hit2, byp_data1, byp_data2
`endif
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd,
        output lsu_ready, pending, we, rd, wd
`ifdef WB_BYPASS_EN
        ,
        input  byp_rs1, byp_rs2,
        output byp_hit1, byp_hit2, byp_data1, byp_data2
`endif
    );

endinterface
`default_nettype wire

// File: rtl/regfile_writeback_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_fifo
// Purpose  : Synchronous FIFO of writeback entries with full/empty/count.
// Revision : 1.0 - initial release
// ============================================================================
module wb_result_fifo
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire                        clk,
    input  wire                        rst,
    input  wire                        push,
    input  wire wb_entry_t             push_data,
    input  wire                        pop,
    output wb_entry_t                  pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Push is refused when full regardless of a same-cycle pop.
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_arbiter
// Purpose  : Merges ALU and buffered load/store results onto the register
//            file write port and tracks pending long-latency writes.
//            Optional same-cycle bypass compare: define WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback_arbiter
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int XLEN_P       = XLEN,
    parameter int REG_ADDR_W_P = REG_ADDR_W,
    parameter int FIFO_DEPTH   = 2
) (
    input  wire                        clk,
    input  wire                        rst,
    regfile_writeback_arbiter_if.slave bus
);
    localparam int NREGS = 2 ** REG_ADDR_W_P;

    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic                       w_fifo_push;
    logic                       w_lsu_ready;
    logic                       w_alu_sel;
    logic                       w_pop;
    wb_entry_t                  w_push_entry;
    wb_entry_t                  w_head;
    logic                       r_we;
    logic [REG_ADDR_W_P-1:0]    r_rd;
    logic [XLEN_P-1:0]          r_wd;
    logic [NREGS-1:0]           r_pending;
    logic [NREGS-1:0]           w_pending_nxt;

    assign w_lsu_ready  = !rst && !w_fifo_full;
    // x0 transfers complete the handshake but never occupy an entry.
    assign w_fifo_push  = bus.lsu_valid && w_lsu_ready && (bus.lsu_rd != REG_X0);
    assign w_push_entry = '{rd: bus.lsu_rd, data: bus.lsu_data};

    assign w_alu_sel    = bus.alu_valid && (bus.alu_rd != REG_X0);
    assign w_pop        = !w_alu_sel && !w_fifo_empty;

    wb_result_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_fifo_push),
        .push_data  (w_push_entry),
        .pop        (w_pop),
        .pop_data   (w_head),
        .full       (w_fifo_full),
        .empty      (w_fifo_empty),
        .count      ()
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we <= 1'b0;
            r_rd <= '0;
            r_wd <= '0;
        end else begin
            r_we <= w_alu_sel || w_pop;
            if (w_alu_sel) begin
                r_rd <= bus.alu_rd;
                r_wd <= bus.alu_data;
            end else if (w_pop) begin
                r_rd <= w_head.rd;
                r_wd <= w_head.data;
            end
        end
    end

    // Retire clears first so a same-index issue in the same cycle wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) begin
            w_pending_nxt[w_head.rd] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != REG_X0)) begin
            w_pending_nxt[bus.issue_rd] = 1'b1;
        end
        w_pending_nxt[REG_X0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign bus.lsu_ready = w_lsu_ready;
    assign bus.pending   = r_pending;
    assign bus.we        = r_we;
    assign bus.rd        = r_rd;
    assign bus.wd        = r_wd;

`ifdef WB_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    assign w_hit1        = r_we && (r_rd == bus.byp_rs1) && (bus.byp_rs1 != REG_X0);
    assign w_hit2        = r_we && (r_rd == bus.byp_rs2) && (bus.byp_rs2 != REG_X0);
    assign bus.byp_hit1  = w_hit1;
    assign bus.byp_hit2  = w_hit2;
    assign bus.byp_data1 = w_hit1 ? r_wd : '0;
    assign bus.byp_data2 = w_hit2 ? r_wd : '0;
`endif

endmodule
`default_nettype wire
